leaf_seq_collector: RTL and testbench

//  Downstream sink of the PEran tree. Captures each 32-bit leaf result (16 nucleotides, 2 bits each)

---
 rtl/leaf_seq_collector_if.sv | 22 ++
 rtl/leaf_seq_collector.sv | 114 +++++++++++
 tb/tb_leaf_seq_collector.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/leaf_seq_collector_if.sv
// Leaf result ingress and ASCII character egress handshakes of the sequence collector.
interface leaf_seq_collector_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_seq;
    logic [2:0]  in_leaf_id;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_char;
    logic [2:0]  out_leaf_id;
    logic        out_last;

    modport slave (
        input  in_valid, in_seq, in_leaf_id, out_ready,
        output in_ready, out_valid, out_char, out_leaf_id, out_last
    );

    modport master (
        output in_valid, in_seq, in_leaf_id, out_ready,
        input  in_ready, out_valid, out_char, out_leaf_id, out_last
    );
endinterface

// File: rtl/leaf_seq_collector.sv
// Buffers 32-bit leaf results in a FIFO and serialises each as 16 ASCII nucleotides.
// Latency: push into an empty FIFO gives the first char two edges later; stalls hold the char stable.
module leaf_seq_collector #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    leaf_seq_collector_if.slave      bus,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    output logic [CNT_W-1:0]         char_count,
    output logic [CNT_W-1:0]         leaf_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    typedef struct packed {
        logic [2:0]  id;
        logic [31:0] seq;
    } entry_t;

    typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    state_t          state;
    state_t          state_nxt;
    logic [31:0]     sreg;
    logic [2:0]      leaf_id;
    logic [3:0]      nib_idx;
    logic            push;
    logic            pop;
    logic            accept;
    logic            fifo_empty;

    assign fifo_empty      = (fifo_level == '0);
    assign bus.in_ready    = (fifo_level != LW'(DEPTH));
    assign push            = bus.in_valid & bus.in_ready;
    assign bus.out_valid   = (state == SEND);
    assign accept          = bus.out_valid & bus.out_ready;
    assign bus.out_leaf_id = leaf_id;
    assign bus.out_last    = (nib_idx == 4'd15) & bus.out_valid;

    always_comb begin
        bus.out_char = 8'h00;
        if (bus.out_valid) begin
            case (sreg[1:0])
                2'b00:   bus.out_char = 8'h41;
                2'b01:   bus.out_char = 8'h43;
                2'b10:   bus.out_char = 8'h47;
                default: bus.out_char = 8'h54;
            endcase
        end
    end

    // Finishing a leaf with more queued pops straight into SEND so leaves abut.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: state_nxt = SEND;
            SEND: begin
                if (accept && nib_idx == 4'd15) begin
                    if (!fifo_empty) pop = 1'b1;
                    else             state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{id: bus.in_leaf_id, seq: bus.in_seq};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
            sreg       <= '0;
            leaf_id    <= '0;
            nib_idx    <= '0;
            char_count <= '0;
            leaf_count <= '0;
        end else begin
            state <= state_nxt;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            fifo_level <= fifo_level + LW'(push) - LW'(pop);
            if (bus.in_valid && !bus.in_ready) overflow <= 1'b1;
            if (pop) begin
                sreg    <= mem[rd_ptr].seq;
                leaf_id <= mem[rd_ptr].id;
                nib_idx <= '0;
            end else if (accept) begin
                sreg    <= {2'b00, sreg[31:2]};
                nib_idx <= nib_idx + 4'd1;
            end
            if (accept) char_count <= char_count + CNT_W'(1);
            if (accept && nib_idx == 4'd15) leaf_count <= leaf_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_leaf_seq_collector.sv
// Directed bench for leaf_seq_collector: reset, latency, backpressure, full FIFO, push/pop, mid-stream reset.
module tb_leaf_seq_collector;
    logic        clk;
    logic        reset;
    logic [3:0]  fifo_level;
    logic        overflow;
    logic [15:0] char_count;
    logic [15:0] leaf_count;

    leaf_seq_collector_if bus ();

    leaf_seq_collector #(.DEPTH(8), .CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .char_count (char_count),
        .leaf_count (leaf_count)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  cap_char [0:159];
    logic [2:0]  cap_id   [0:159];
    logic        cap_last [0:159];
    int          cap_n, cap_bad_stall, cap_bubbles, cap_stalls;

    logic [31:0] exp_seq [0:15];
    logic [2:0]  exp_id  [0:15];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required finish before it");
        $fatal(1);
    end

    function automatic logic [7:0] exp_char(input logic [31:0] s, input int nib);
        logic [1:0] b;
        b = s[2*nib +: 2];
        case (b)
            2'b00:   return 8'h41;
            2'b01:   return 8'h43;
            2'b10:   return 8'h47;
            default: return 8'h54;
        endcase
    endfunction

    function automatic int stream_errs(input int n);
        int e = 0;
        for (int k = 0; k < n; k++) begin
            if (cap_char[k] !== exp_char(exp_seq[k/16], k%16) || cap_id[k] !== exp_id[k/16] ||
                cap_last[k] !== ((k % 16) == 15))
                e++;
        end
        return e;
    endfunction

    task automatic push(input logic [31:0] s, input logic [2:0] id);
        bus.in_valid   = 1'b1;
        bus.in_seq     = s;
        bus.in_leaf_id = id;
        @(posedge clk); #1;
        bus.in_valid   = 1'b0;
    endtask

    // Records accepted chars; notes stall instability and gaps after the first accept.
    task automatic capture(input int n, input bit rnd, input int budget);
        logic stalled;
        logic [7:0] pc;
        logic [2:0] pid;
        logic pl;
        cap_n = 0; cap_bad_stall = 0; cap_bubbles = 0; cap_stalls = 0;
        stalled = 1'b0; pc = '0; pid = '0; pl = 1'b0;
        for (int c = 0; c < budget && cap_n < n; c++) begin
            bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stalled && (bus.out_valid !== 1'b1 || bus.out_char !== pc ||
                            bus.out_leaf_id !== pid || bus.out_last !== pl))
                cap_bad_stall++;
            if (bus.out_valid === 1'b1 && bus.out_ready) begin
                cap_char[cap_n] = bus.out_char;
                cap_id[cap_n]   = bus.out_leaf_id;
                cap_last[cap_n] = bus.out_last;
                cap_n++;
            end else if (bus.out_valid !== 1'b1 && cap_n > 0) begin
                cap_bubbles++;
            end
            stalled = (bus.out_valid === 1'b1) && !bus.out_ready;
            if (stalled) cap_stalls++;
            pc = bus.out_char; pid = bus.out_leaf_id; pl = bus.out_last;
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.in_valid = 1'b1; bus.in_seq = 32'hDEAD_BEEF; bus.in_leaf_id = 3'd7; bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b expected 1", bus.in_ready); else n_pass++;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.out_char !== 8'h00) $display("FAIL rst_out_char: got %h expected 00", bus.out_char); else n_pass++;
        n_checks++; if (bus.out_last !== 1'b0 || bus.out_leaf_id !== 3'd0) $display("FAIL rst_last_id: got %b/%0d expected 0/0", bus.out_last, bus.out_leaf_id); else n_pass++;
        n_checks++; if (fifo_level !== 4'd0 || overflow !== 1'b0) $display("FAIL rst_level_ovf: got %0d/%b expected 0/0", fifo_level, overflow); else n_pass++;
        n_checks++; if (char_count !== 16'd0 || leaf_count !== 16'd0) $display("FAIL rst_counts: got %0d/%0d expected 0/0", char_count, leaf_count); else n_pass++;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        n_checks++; if (fifo_level !== 4'd0 || bus.out_valid !== 1'b0) $display("FAIL rst_nothing_stored: got level %0d valid %b expected 0/0", fifo_level, bus.out_valid); else n_pass++;
    endtask

    task automatic test_single();
        int e;
        push(32'hE4E4_E4E4, 3'd5);
        n_checks++; if (bus.out_valid !== 1'b0 || fifo_level !== 4'd1) $display("FAIL single_after_push: got valid %b level %0d expected 0/1", bus.out_valid, fifo_level); else n_pass++;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL single_latency_n1: got %b expected 0", bus.out_valid); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_char !== 8'h41 || bus.out_leaf_id !== 3'd5) $display("FAIL single_first_char: got %b/%h/%0d expected 1/41/5", bus.out_valid, bus.out_char, bus.out_leaf_id); else n_pass++;
        exp_seq[0] = 32'hE4E4_E4E4; exp_id[0] = 3'd5;
        capture(16, 1'b0, 40);
        e = stream_errs(cap_n);
        n_checks++; if (cap_n !== 16 || e !== 0) $display("FAIL single_stream: got %0d chars %0d bad expected 16 chars 0 bad", cap_n, e); else n_pass++;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL single_idle_after: got %b expected 0", bus.out_valid); else n_pass++;
        n_checks++; if (char_count !== 16'd16 || leaf_count !== 16'd1) $display("FAIL single_counts: got %0d/%0d expected 16/1", char_count, leaf_count); else n_pass++;
    endtask

    task automatic test_backpressure();
        int e;
        exp_seq[0] = 32'h1B1B_1B1B; exp_id[0] = 3'd1;
        exp_seq[1] = 32'h0000_FFFF; exp_id[1] = 3'd2;
        push(exp_seq[0], exp_id[0]);
        push(exp_seq[1], exp_id[1]);
        capture(32, 1'b1, 500);
        e = stream_errs(cap_n);
        n_checks++; if (cap_n !== 32 || e !== 0) $display("FAIL bp_stream: got %0d chars %0d bad expected 32 chars 0 bad", cap_n, e); else n_pass++;
        n_checks++; if (cap_bad_stall !== 0) $display("FAIL bp_stall_stable: got %0d unstable cycles expected 0", cap_bad_stall); else n_pass++;
        n_checks++; if (cap_stalls == 0) $display("FAIL bp_stalls_seen: got 0 stall cycles expected nonzero"); else n_pass++;
        n_checks++; if (char_count !== 16'd48 || leaf_count !== 16'd3) $display("FAIL bp_counts: got %0d/%0d expected 48/3", char_count, leaf_count); else n_pass++;
    endtask

    task automatic test_full();
        int e, refused;
        refused = 0;
        exp_seq[0] = 32'h0000_0000; exp_id[0] = 3'd6;
        push(exp_seq[0], exp_id[0]);
        for (int k = 1; k <= 8; k++) begin
            exp_seq[k] = 32'h1357_9BDF ^ (32'h0F0F_3C3C * k);
            exp_id[k]  = 3'(k - 1);
            if (bus.in_ready !== 1'b1) refused++;
            push(exp_seq[k], exp_id[k]);
        end
        n_checks++; if (refused !== 0) $display("FAIL full_ready_while_filling: got %0d refusals expected 0", refused); else n_pass++;
        n_checks++; if (fifo_level !== 4'd8 || bus.in_ready !== 1'b0) $display("FAIL full_level: got %0d ready %b expected 8/0", fifo_level, bus.in_ready); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL full_no_ovf_yet: got %b expected 0", overflow); else n_pass++;
        push(32'hFFFF_FFFF, 3'd7);
        n_checks++; if (overflow !== 1'b1 || fifo_level !== 4'd8) $display("FAIL full_drop: got ovf %b level %0d expected 1/8", overflow, fifo_level); else n_pass++;
        capture(144, 1'b0, 400);
        e = stream_errs(cap_n);
        n_checks++; if (cap_n !== 144 || e !== 0) $display("FAIL full_drain: got %0d chars %0d bad expected 144 chars 0 bad", cap_n, e); else n_pass++;
        n_checks++; if (cap_bubbles !== 0) $display("FAIL full_no_bubble: got %0d gaps expected 0", cap_bubbles); else n_pass++;
        n_checks++; if (bus.out_valid !== 1'b0 || fifo_level !== 4'd0 || overflow !== 1'b1) $display("FAIL full_after: got valid %b level %0d ovf %b expected 0/0/1", bus.out_valid, fifo_level, overflow); else n_pass++;
        n_checks++; if (char_count !== 16'd192 || leaf_count !== 16'd12) $display("FAIL full_counts: got %0d/%0d expected 192/12", char_count, leaf_count); else n_pass++;
    endtask

    task automatic test_push_pop();
        int e;
        bit found;
        logic [31:0] seq_a;
        seq_a = 32'hA5A5_0F0F;
        exp_seq[0] = 32'h2468_ACE0; exp_id[0] = 3'd3;
        exp_seq[1] = 32'h7777_1111; exp_id[1] = 3'd4;
        exp_seq[2] = 32'h0F1E_2D3C; exp_id[2] = 3'd0;
        exp_seq[3] = 32'hE4E4_1B1B; exp_id[3] = 3'd7;
        push(seq_a, 3'd2);
        for (int k = 0; k < 3; k++) push(exp_seq[k], exp_id[k]);
        n_checks++; if (fifo_level !== 4'd3) $display("FAIL pp_setup_level: got %0d expected 3", fifo_level); else n_pass++;
        bus.out_ready = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            if (bus.out_last === 1'b1) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        n_checks++; if (!found) $display("FAIL pp_reach_last: got no out_last within 60 cycles expected one"); else n_pass++;
        push(exp_seq[3], exp_id[3]);
        n_checks++; if (fifo_level !== 4'd3) $display("FAIL pp_level_kept: got %0d expected 3", fifo_level); else n_pass++;
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_leaf_id !== 3'd3) $display("FAIL pp_back_to_back: got %b/%0d expected 1/3", bus.out_valid, bus.out_leaf_id); else n_pass++;
        capture(64, 1'b0, 200);
        e = stream_errs(cap_n);
        n_checks++; if (cap_n !== 64 || e !== 0) $display("FAIL pp_order: got %0d chars %0d bad expected 64 chars 0 bad", cap_n, e); else n_pass++;
        n_checks++; if (char_count !== 16'd272 || leaf_count !== 16'd17) $display("FAIL pp_counts: got %0d/%0d expected 272/17", char_count, leaf_count); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int e;
        bus.out_ready = 1'b0;
        push(32'hE4E4_E4E4, 3'd1);
        push(32'h1111_2222, 3'd2);
        push(32'h3333_4444, 3'd3);
        capture(7, 1'b0, 50);
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_char !== 8'h54 || fifo_level !== 4'd2) $display("FAIL mid_pre_reset: got %b/%h/%0d expected 1/54/2", bus.out_valid, bus.out_char, fifo_level); else n_pass++;
        reset = 1'b0;
        #2;
        n_checks++; if (bus.out_valid !== 1'b0 || bus.out_char !== 8'h00 || bus.out_last !== 1'b0 || bus.out_leaf_id !== 3'd0) $display("FAIL mid_outputs: got %b/%h/%b/%0d expected 0/00/0/0", bus.out_valid, bus.out_char, bus.out_last, bus.out_leaf_id); else n_pass++;
        n_checks++; if (fifo_level !== 4'd0 || bus.in_ready !== 1'b1 || overflow !== 1'b0) $display("FAIL mid_fifo: got level %0d ready %b ovf %b expected 0/1/0", fifo_level, bus.in_ready, overflow); else n_pass++;
        n_checks++; if (char_count !== 16'd0 || leaf_count !== 16'd0) $display("FAIL mid_counts: got %0d/%0d expected 0/0", char_count, leaf_count); else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        bus.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        n_checks++; if (bus.out_valid !== 1'b0 || char_count !== 16'd0) $display("FAIL mid_quiet: got valid %b chars %0d expected 0/0", bus.out_valid, char_count); else n_pass++;
        exp_seq[0] = 32'h1B1B_1B1B; exp_id[0] = 3'd4;
        push(exp_seq[0], exp_id[0]);
        capture(16, 1'b0, 40);
        e = stream_errs(cap_n);
        n_checks++; if (cap_n !== 16 || e !== 0) $display("FAIL mid_clean_leaf: got %0d chars %0d bad expected 16 chars 0 bad", cap_n, e); else n_pass++;
        n_checks++; if (char_count !== 16'd16 || leaf_count !== 16'd1) $display("FAIL mid_clean_counts: got %0d/%0d expected 16/1", char_count, leaf_count); else n_pass++;
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_seq = '0; bus.in_leaf_id = '0; bus.out_ready = 1'b0;
        reset = 1'b1;
        #1;
        test_reset();
        test_single();
        test_backpressure();
        test_full();
        test_push_pop();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
